delay_timer: RTL and testbench

Parametrised, synchronous programmable delay timer for the irrigation controller. A prescaler derives a slow tick from the system clock, and a down-counter measures a programmable number of ticks in one-shot or periodic mode. It sits between the control FSM and the valve/pump drivers and times irrigation on/off intervals. All flops share the single system clock; there is no rippled clock.

---
 rtl/delay_pkg.sv | 10 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/delay_timer.sv | 112 +++++++++++
 tb/tb_delay_timer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// rtl/delay_pkg.sv - shared types and time-base constants for the delay timer
// Default DIV values assume a 50 MHz system clock.
package delay_pkg;

  typedef enum logic {IDLE, RUN} delay_state_t;

  localparam int DIV_1MS = 50_000;
  localparam int DIV_1S  = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - mod-DIV counter producing a one-cycle tick at terminal count
// Counts only while en is high; clr returns it to zero and takes priority.
module tick_prescaler
  import delay_pkg::*;
#(
  parameter int DIV   = DIV_1MS,
  parameter int PRE_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - programmable one-shot/periodic delay timer on a prescaled tick
// Optional macro DELAY_TIMER_CLKOUT_EN adds the clk_div square-wave output.
module delay_timer
  import delay_pkg::*;
#(
  parameter int DIV     = DIV_1MS,
  parameter int PRE_W   = $clog2(DIV),
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [COUNT_W-1:0] duration,
  output logic               busy,
  output logic               done,
  output logic               tick,
  output logic [COUNT_W-1:0] remaining
`ifdef DELAY_TIMER_CLKOUT_EN
  ,
  output logic               clk_div
`endif
);

  delay_state_t       state, state_n;
  logic [COUNT_W-1:0] remaining_n;
  logic [COUNT_W-1:0] reload, reload_n;
  logic               periodic_q, periodic_n;
  logic               done_n;
  logic               pre_clr;

  // Prescaler restarts on every accepted start and sits at zero whenever we leave RUN.
  assign pre_clr = (start && !stop) || (state_n == IDLE);
  assign busy    = (state == RUN);

  tick_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .en   (state == RUN),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    reload_n    = reload;
    periodic_n  = periodic_q;
    done_n      = 1'b0;
    if (stop) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else if (start) begin
      if (duration != '0) begin
        state_n     = RUN;
        remaining_n = duration;
        reload_n    = duration;
        periodic_n  = periodic;
      end else begin
        state_n     = IDLE;
        remaining_n = '0;
        done_n      = 1'b1;
      end
    end else if (tick) begin
      if (remaining == COUNT_W'(1)) begin
        done_n = 1'b1;
        if (periodic_q) begin
          remaining_n = reload;
        end else begin
          remaining_n = '0;
          state_n     = IDLE;
        end
      end else if (remaining != '0) begin
        remaining_n = remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      remaining  <= '0;
      reload     <= '0;
      periodic_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      reload     <= reload_n;
      periodic_q <= periodic_n;
      done       <= done_n;
    end
  end

`ifdef DELAY_TIMER_CLKOUT_EN
  // Data-only square wave; never used to clock anything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_div <= 1'b0;
    end else if (state_n == IDLE) begin
      clk_div <= 1'b0;
    end else if (tick) begin
      clk_div <= ~clk_div;
    end
  end
`endif

endmodule

// File: tb/tb_delay_timer.sv
// tb/tb_delay_timer.sv - directed self-checking bench for delay_timer (DIV=4, COUNT_W=8)
// Define DELAY_TIMER_CLKOUT_EN to also check clk_div.
module tb_delay_timer;

  localparam int DIV     = 4;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               rstn;
  logic               start;
  logic               stop;
  logic               periodic;
  logic [COUNT_W-1:0] duration;
  logic               busy;
  logic               done;
  logic               tick;
  logic [COUNT_W-1:0] remaining;
`ifdef DELAY_TIMER_CLKOUT_EN
  logic               clk_div;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  delay_timer #(
    .DIV     (DIV),
    .COUNT_W (COUNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .duration  (duration),
    .busy      (busy),
    .done      (done),
    .tick      (tick),
    .remaining (remaining)
`ifdef DELAY_TIMER_CLKOUT_EN
    ,
    .clk_div   (clk_div)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [COUNT_W-1:0] dur, input logic per);
    start    = 1'b1;
    duration = dur;
    periodic = per;
    step();
    start    = 1'b0;
    periodic = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    duration = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tick", tick, 0);
    check("rst_remaining", remaining, 0);
`ifdef DELAY_TIMER_CLKOUT_EN
    check("rst_clk_div", clk_div, 0);
`endif
    rstn = 1'b1;
    step();

    // One-shot, duration 3: ticks after edges 3,7,11; done after edge 12.
    launch(8'd3, 1'b0);
    check("os_busy0", busy, 1);
    check("os_rem0", remaining, 3);
    check("os_tick0", tick, 0);
    for (int e = 1; e <= 14; e++) begin
      step();
      check($sformatf("os_tick_e%0d", e), tick, (e == 3 || e == 7 || e == 11) ? 1 : 0);
      check($sformatf("os_done_e%0d", e), done, (e == 12) ? 1 : 0);
      check($sformatf("os_busy_e%0d", e), busy, (e < 12) ? 1 : 0);
      check($sformatf("os_rem_e%0d", e), remaining,
            (e < 4) ? 3 : (e < 8) ? 2 : (e < 12) ? 1 : 0);
`ifdef DELAY_TIMER_CLKOUT_EN
      check($sformatf("os_clkdiv_e%0d", e), clk_div, (e >= 4 && e < 8) ? 1 : 0);
`endif
    end

    // Periodic, duration 2: done after edges 8,16,24; remaining reloads.
    launch(8'd2, 1'b1);
    for (int e = 1; e <= 25; e++) begin
      step();
      check($sformatf("per_done_e%0d", e), done, (e % 8 == 0) ? 1 : 0);
      check($sformatf("per_busy_e%0d", e), busy, 1);
      check($sformatf("per_rem_e%0d", e), remaining, ((e / 4) % 2 == 0) ? 2 : 1);
    end
    abort();
    check("per_stop_busy", busy, 0);
    check("per_stop_rem", remaining, 0);

    // Stop at edge 6, alone and with a simultaneous start.
    for (int v = 0; v < 2; v++) begin
      launch(8'd3, 1'b0);
      for (int e = 1; e <= 5; e++) step();
      start    = (v == 1);
      duration = 8'd5;
      stop     = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check($sformatf("stop%0d_busy", v), busy, 0);
      check($sformatf("stop%0d_rem", v), remaining, 0);
      check($sformatf("stop%0d_done", v), done, 0);
      for (int e = 7; e <= 14; e++) begin
        step();
        check($sformatf("stop%0d_done_e%0d", v, e), done, 0);
        check($sformatf("stop%0d_busy_e%0d", v, e), busy, 0);
      end
    end

    // Retrigger at edge 10 with duration 1: done after edge 14, not 12.
    launch(8'd3, 1'b0);
    for (int e = 1; e <= 9; e++) step();
    launch(8'd1, 1'b0);
    check("rt_rem10", remaining, 1);
    check("rt_busy10", busy, 1);
    for (int e = 11; e <= 16; e++) begin
      step();
      check($sformatf("rt_done_e%0d", e), done, (e == 14) ? 1 : 0);
      check($sformatf("rt_busy_e%0d", e), busy, (e < 14) ? 1 : 0);
    end

    // Retrigger coincident with expiry tick at edge 12 suppresses done.
    launch(8'd3, 1'b0);
    for (int e = 1; e <= 11; e++) step();
    check("rtx_tick11", tick, 1);
    check("rtx_rem11", remaining, 1);
    launch(8'd2, 1'b0);
    check("rtx_done12", done, 0);
    check("rtx_busy12", busy, 1);
    check("rtx_rem12", remaining, 2);
    abort();

    // Zero duration from IDLE and from RUN.
    launch(8'd0, 1'b0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_rem", remaining, 0);
    step();
    check("z_done_next", done, 0);
    check("z_busy_next", busy, 0);
    launch(8'd3, 1'b0);
    step();
    launch(8'd0, 1'b0);
    check("zr_done", done, 1);
    check("zr_busy", busy, 0);
    check("zr_rem", remaining, 0);
    step();
    check("zr_done_next", done, 0);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    launch(8'd3, 1'b0);
    for (int e = 1; e <= 6; e++) step();
    check("ar_busy_pre", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_rem", remaining, 0);
    check("ar_tick", tick, 0);
    check("ar_done", done, 0);
`ifdef DELAY_TIMER_CLKOUT_EN
    check("ar_clk_div", clk_div, 0);
`endif
    step();
    step();
    #2;
    rstn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      check($sformatf("ar_idle_busy_%0d", e), busy, 0);
      check($sformatf("ar_idle_done_%0d", e), done, 0);
      check($sformatf("ar_idle_tick_%0d", e), tick, 0);
      check($sformatf("ar_idle_rem_%0d", e), remaining, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
